updown_counter: RTL and testbench

//  Parametrised loadable up/down counter with programmable modulus and

---
 rtl/updown_counter.sv | 63 ++++++
 tb/tb_updown_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Loadable up/down counter with programmable modulus, terminal-count and wrap flags.
// Define COUNTER_SAT_EN to hold the count at a boundary step instead of wrapping.
module updown_counter #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned MAX_VAL   = (1 << WIDTH) - 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero, boundary;

  always_comb begin
    at_max   = (cnt_q == MAX_W);
    at_zero  = (cnt_q == '0);
    boundary = en & ((up & at_max) | (~up & at_zero));
    tc       = boundary & ~load;

    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = (cnt_in > MAX_W) ? MAX_W : cnt_in;
    end else if (en) begin
      if (boundary) begin
        wrap_d = 1'b1;
`ifdef COUNTER_SAT_EN
        cnt_d = cnt_q;
`else
        cnt_d = up ? '0 : MAX_W;
`endif
      end else begin
        cnt_d = up ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= RST_W;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_out = cnt_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: full-range 5-bit instance and a MAX_VAL=9 instance,
// plus a randomized stretch on the modulus-9 instance against a reference model.
module tb_updown_counter;

`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       a_load, a_en, a_up;
  logic [4:0] a_cnt_in, a_cnt;
  logic       a_tc, a_wrap;
  logic       b_load, b_en, b_up;
  logic [4:0] b_cnt_in, b_cnt;
  logic       b_tc, b_wrap;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(5)) u_full (
    .clk(clk), .rst(rst), .load(a_load), .en(a_en), .up(a_up),
    .cnt_in(a_cnt_in), .cnt_out(a_cnt), .tc(a_tc), .wrap(a_wrap)
  );

  updown_counter #(.WIDTH(5), .MAX_VAL(9), .RESET_VAL(0)) u_mod9 (
    .clk(clk), .rst(rst), .load(b_load), .en(b_en), .up(b_up),
    .cnt_in(b_cnt_in), .cnt_out(b_cnt), .tc(b_tc), .wrap(b_wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] m;
    logic       mw, etc, ld, e, u;
    logic [4:0] cin;

    rst = 1'b0;
    a_load = 0; a_en = 0; a_up = 0; a_cnt_in = '0;
    b_load = 0; b_en = 0; b_up = 0; b_cnt_in = '0;
    #2;
    check("rst_cnt", a_cnt, 0);
    check("rst_wrap", a_wrap, 0);
    check("rst_tc_idle", a_tc, 0);
    a_en = 1; a_up = 0;
    #1;
    check("rst_tc_down_at0", a_tc, 1);
    a_en = 0;
    #5 rst = 1'b1;
    tick();

    // Test 1: reset mid-count
    a_load = 1; a_cnt_in = 5'd7;
    tick();
    a_load = 0;
    check("t1_loaded7", a_cnt, 7);
    #2 rst = 1'b0;
    #1;
    check("t1_async_cnt", a_cnt, 0);
    check("t1_async_wrap", a_wrap, 0);
    #1 rst = 1'b1;
    tick();
    check("t1_hold_cnt", a_cnt, 0);
    check("t1_hold_wrap", a_wrap, 0);

    // Test 2 / 5: top boundary on the full-range counter
    a_load = 1; a_cnt_in = 5'd30;
    tick();
    check("t2_load30", a_cnt, 30);
    a_load = 0; a_en = 1; a_up = 1;
    #1;
    check("t2_tc_at30", a_tc, 0);
    tick();
    check("t2_cnt31", a_cnt, 31);
    check("t2_wrap_at31", a_wrap, 0);
    check("t2_tc_at31", a_tc, 1);
    tick();
    check("t2_cnt_step1", a_cnt, SAT ? 31 : 0);
    check("t2_wrap_step1", a_wrap, 1);
    check("t2_tc_step1", a_tc, SAT ? 1 : 0);
    tick();
    check("t2_cnt_step2", a_cnt, SAT ? 31 : 1);
    check("t2_wrap_step2", a_wrap, SAT ? 1 : 0);
    a_up = 0;
    #1;
    check("t2_tc_dirchg", a_tc, 0);
    tick();
    check("t2_cnt_down", a_cnt, SAT ? 30 : 0);
    check("t2_wrap_down", a_wrap, 0);
    check("t2_tc_down", a_tc, SAT ? 0 : 1);
    a_en = 0;
    tick();
    check("t2_hold_cnt", a_cnt, SAT ? 30 : 0);
    check("t2_hold_wrap", a_wrap, 0);
    check("t2_hold_tc", a_tc, 0);

    // Reset while a wrap pulse is active
    a_load = 1; a_cnt_in = 5'd31;
    tick();
    a_load = 0; a_en = 1; a_up = 1;
    tick();
    check("rw_wrap_set", a_wrap, 1);
    a_en = 0;
    #1 rst = 1'b0;
    #1;
    check("rw_wrap_clr", a_wrap, 0);
    check("rw_cnt_clr", a_cnt, 0);
    #1 rst = 1'b1;
    tick();
    check("rw_no_pulse", a_wrap, 0);

    // Test 3: bottom boundary with MAX_VAL=9
    b_load = 1; b_cnt_in = 5'd0;
    tick();
    b_load = 0; b_en = 1; b_up = 0;
    #1;
    check("t3_tc_at0", b_tc, 1);
    tick();
    check("t3_cnt_s1", b_cnt, SAT ? 0 : 9);
    check("t3_wrap_s1", b_wrap, 1);
    tick();
    check("t3_cnt_s2", b_cnt, SAT ? 0 : 8);
    check("t3_wrap_s2", b_wrap, SAT ? 1 : 0);
    tick();
    check("t3_cnt_s3", b_cnt, SAT ? 0 : 7);

    // Test 4: clamp and load priority
    b_en = 0; b_load = 1; b_cnt_in = 5'd20;
    tick();
    check("t4_clamp", b_cnt, 9);
    check("t4_clamp_wrap", b_wrap, 0);
    b_en = 1; b_up = 1; b_cnt_in = 5'd4;
    #1;
    check("t4_tc_masked", b_tc, 0);
    tick();
    check("t4_load_wins", b_cnt, 4);
    check("t4_load_wrap", b_wrap, 0);

    // Top boundary at MAX_VAL=9
    b_cnt_in = 5'd8;
    tick();
    b_load = 0;
    tick();
    check("m9_cnt9", b_cnt, 9);
    check("m9_tc9", b_tc, 1);
    tick();
    check("m9_cnt_wrap", b_cnt, SAT ? 9 : 0);
    check("m9_wrap", b_wrap, 1);

    // Randomized stretch vs reference model
    b_en = 0; b_load = 1; b_cnt_in = 5'd0;
    tick();
    m = 5'd0; mw = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ld  = ($urandom_range(0, 7) == 0);
      e   = ($urandom_range(0, 3) != 0);
      u   = $urandom_range(0, 1) == 1;
      cin = 5'($urandom_range(0, 31));
      b_load = ld; b_en = e; b_up = u; b_cnt_in = cin;
      etc = e & ~ld & ((u & (m == 5'd9)) | (~u & (m == 5'd0)));
      #1;
      check("rnd_tc", b_tc, etc);
      if (ld) begin
        m  = (cin > 5'd9) ? 5'd9 : cin;
        mw = 1'b0;
      end else if (e && u && m == 5'd9) begin
        m  = SAT ? 5'd9 : 5'd0;
        mw = 1'b1;
      end else if (e && !u && m == 5'd0) begin
        m  = SAT ? 5'd0 : 5'd9;
        mw = 1'b1;
      end else if (e) begin
        m  = u ? m + 5'd1 : m - 5'd1;
        mw = 1'b0;
      end else begin
        mw = 1'b0;
      end
      tick();
      check("rnd_cnt", b_cnt, m);
      check("rnd_wrap", b_wrap, mw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
